// File: rtl/mem_load_scheduler_pkg.sv
// Shared types and sizing helpers for the DRAM-to-memory load scheduler.
package mem_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_CLR    = 3'd2,
    ST_CMD    = 3'd3,
    ST_STREAM = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // DRAM beats needed to fill one memory word.
  function automatic int div_ceiling(input int in_w, input int out_w);
    return (out_w + in_w - 1) / in_w;
  endfunction

  // The packer only needs an extra write-trigger event when a word spans several beats.
  function automatic bit flush_en(input int in_w, input int out_w);
    return in_w < out_w;
  endfunction

  function automatic int beat_cnt_w(input int in_w, input int out_w);
    return $clog2(div_ceiling(in_w, out_w) + 1);
  endfunction

endpackage

// File: rtl/mem_load_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic found_s;
  int   cand_s;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = (int'(ptr_i) + off) % NUM_REQ;
      if (!found_s && req_i[cand_s]) begin
        gnt_o[cand_s] = 1'b1;
        idx_o         = PTR_W'(cand_s);
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mem_load_scheduler.sv
// Round-robin DRAM load scheduler: one read command per job, paces bytes into the
// packer and steers the packer's word writes to the granted on-chip memory.
module mem_load_scheduler
  import mem_load_pkg::*;
#(
  parameter int NUM_REQ           = 3,
  parameter int DATA_IN_BITWIDTH  = 8,
  parameter int DATA_OUT_BITWIDTH = 163,
  parameter int ADDR_W            = 10,
  parameter int DRAM_ADDR_W       = 32,
  parameter int LEN_W             = 10
) (
  input  logic                           clk_i,
  input  logic                           mem_load_rst_ni,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*DRAM_ADDR_W-1:0] req_dram_addr_i,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_mem_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]       req_len_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           busy_o,
  output logic                           dram_cmd_valid_o,
  input  logic                           dram_cmd_ready_i,
  output logic [DRAM_ADDR_W-1:0]         dram_cmd_addr_o,
  output logic [LEN_W+4:0]               dram_cmd_beats_o,
  input  logic                           dram_data_valid_i,
  input  logic [DATA_IN_BITWIDTH-1:0]    dram_data_i,
  output logic                           dram_data_ready_o,
  output logic                           packer_rst_o,
  output logic [DATA_IN_BITWIDTH-1:0]    packer_data_o,
  output logic                           packer_valid_o,
  input  logic                           packer_we_i,
  output logic [NUM_REQ-1:0]             mem_we_o,
  output logic [ADDR_W-1:0]              mem_addr_o
);

  localparam int DIVC  = div_ceiling(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH);
  localparam bit FLUSH = flush_en(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH);
  localparam int BCW   = beat_cnt_w(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                      state_q;
  logic [PTR_W-1:0]            ptr_q;
  logic [PTR_W-1:0]            idx_q;
  logic [NUM_REQ-1:0]          grant_q;
  logic [NUM_REQ-1:0]          done_q;
  logic [NUM_REQ-1:0]          mem_we_q;
  logic                        cmd_valid_q;
  logic [DRAM_ADDR_W-1:0]      cmd_addr_q;
  logic [LEN_W+4:0]            cmd_beats_q;
  logic                        pk_rst_q;
  logic [DATA_IN_BITWIDTH-1:0] pk_data_q;
  logic                        pk_valid_q;
  logic [1:0]                  phase_q;
  logic [BCW-1:0]              beat_cnt_q;
  logic [LEN_W-1:0]            groups_q;
  logic [LEN_W-1:0]            word_idx_q;
  logic [LEN_W-1:0]            len_q;
  logic [ADDR_W-1:0]           mem_base_q;
  logic [ADDR_W-1:0]           mem_addr_q;
  logic                        we_prev_q;

  logic [NUM_REQ-1:0]     arb_gnt_s;
  logic [PTR_W-1:0]       arb_idx_s;
  logic [DRAM_ADDR_W-1:0] sel_dram_s;
  logic [ADDR_W-1:0]      sel_base_s;
  logic [LEN_W-1:0]       sel_len_s;
  logic                   stream_free_s;
  logic                   data_ready_s;
  logic                   flush_s;
  logic                   beat_accept_s;
  logic                   we_rise_s;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt_s),
    .idx_o(arb_idx_s)
  );

  // One-hot AND-OR mux of the granted requester's job descriptor.
  always_comb begin
    sel_dram_s = '0;
    sel_base_s = '0;
    sel_len_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_dram_s = sel_dram_s | ({DRAM_ADDR_W{arb_gnt_s[i]}} & req_dram_addr_i[i*DRAM_ADDR_W +: DRAM_ADDR_W]);
      sel_base_s = sel_base_s | ({ADDR_W{arb_gnt_s[i]}} & req_mem_addr_i[i*ADDR_W +: ADDR_W]);
      sel_len_s  = sel_len_s  | ({LEN_W{arb_gnt_s[i]}} & req_len_i[i*LEN_W +: LEN_W]);
    end
  end

  // A new packer event may start only once the previous 2-cycle event has ended.
  assign stream_free_s = (state_q == ST_STREAM) && (phase_q == 2'd0) && (groups_q < len_q);
  assign data_ready_s  = stream_free_s && (beat_cnt_q < BCW'(DIVC));
  assign flush_s       = FLUSH && stream_free_s && (beat_cnt_q == BCW'(DIVC));
  assign beat_accept_s = data_ready_s && dram_data_valid_i;
  assign we_rise_s     = packer_we_i && !we_prev_q;

  // Job sequencing FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!mem_load_rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      mem_we_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_beats_q <= '0;
      pk_rst_q    <= 1'b1;
      pk_data_q   <= '0;
      pk_valid_q  <= 1'b0;
      phase_q     <= 2'd0;
      beat_cnt_q  <= '0;
      groups_q    <= '0;
      word_idx_q  <= '0;
      len_q       <= '0;
      mem_base_q  <= '0;
      mem_addr_q  <= '0;
      we_prev_q   <= 1'b0;
    end else begin
      done_q    <= '0;
      mem_we_q  <= '0;
      we_prev_q <= packer_we_i;
      case (state_q)
        ST_IDLE: begin
          pk_rst_q <= 1'b0;
          if (|req_i) state_q <= ST_ARB;
          else        state_q <= ST_IDLE;
        end
        ST_ARB: begin
          if (arb_gnt_s == '0) begin
            state_q <= ST_IDLE;
          end else begin
            grant_q     <= arb_gnt_s;
            idx_q       <= arb_idx_s;
            cmd_addr_q  <= sel_dram_s;
            cmd_beats_q <= (LEN_W+5)'(sel_len_s) * (LEN_W+5)'(DIVC);
            mem_base_q  <= sel_base_s;
            len_q       <= sel_len_s;
            beat_cnt_q  <= '0;
            groups_q    <= '0;
            word_idx_q  <= '0;
            phase_q     <= 2'd0;
            if (sel_len_s == '0) begin
              state_q <= ST_DONE;
              done_q  <= arb_gnt_s;
            end else begin
              state_q  <= ST_CLR;
              pk_rst_q <= 1'b1;
            end
          end
        end
        ST_CLR: begin
          pk_rst_q    <= 1'b0;
          cmd_valid_q <= 1'b1;
          state_q     <= ST_CMD;
        end
        ST_CMD: begin
          if (dram_cmd_ready_i) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_STREAM;
          end else begin
            cmd_valid_q <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (phase_q != 2'd0) begin
            phase_q <= phase_q - 2'd1;
            if (phase_q == 2'd1) pk_valid_q <= 1'b0;
            else                 pk_valid_q <= 1'b1;
          end else if (beat_accept_s) begin
            pk_data_q  <= dram_data_i;
            pk_valid_q <= 1'b1;
            phase_q    <= 2'd2;
            if (FLUSH) beat_cnt_q <= beat_cnt_q + BCW'(1);
            else       groups_q   <= groups_q + LEN_W'(1);
          end else if (flush_s) begin
            // Byte-less event: the packer emits the completed word on it.
            pk_valid_q <= 1'b1;
            phase_q    <= 2'd2;
            beat_cnt_q <= '0;
            groups_q   <= groups_q + LEN_W'(1);
          end else begin
            pk_valid_q <= 1'b0;
          end
          if (we_rise_s) begin
            mem_we_q   <= grant_q;
            mem_addr_q <= mem_base_q + ADDR_W'(word_idx_q);
            word_idx_q <= word_idx_q + LEN_W'(1);
          end else begin
            mem_we_q <= '0;
          end
          if (word_idx_q == len_q) begin
            state_q <= ST_DONE;
            done_q  <= grant_q;
          end else begin
            state_q <= ST_STREAM;
          end
        end
        ST_DONE: begin
          grant_q    <= '0;
          pk_valid_q <= 1'b0;
          phase_q    <= 2'd0;
          ptr_q      <= (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o           = grant_q;
  assign done_o            = done_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign dram_cmd_valid_o  = cmd_valid_q;
  assign dram_cmd_addr_o   = cmd_addr_q;
  assign dram_cmd_beats_o  = cmd_beats_q;
  assign dram_data_ready_o = data_ready_s;
  assign packer_rst_o      = pk_rst_q;
  assign packer_data_o     = pk_data_q;
  assign packer_valid_o    = pk_valid_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;

endmodule
